// File: rtl/edc_mem_reader_if.sv
// Bus bundle for edc_mem_reader: codeword write port, read request/response and status.
interface edc_mem_reader_if #(
   parameter int unsigned AW    = 4,
   parameter int unsigned CNT_W = 16
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [6:0]       wr_code;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic             scrub_en;
   logic             rd_valid;
   logic [3:0]       rd_data;
   logic             rd_err;
   logic [CNT_W-1:0] err_count;
   logic             wb_overflow;
   logic [AW-1:0]    scrub_addr;

   modport master (
      output wr_en, wr_addr, wr_code, rd_req, rd_addr, scrub_en,
      input  rd_valid, rd_data, rd_err, err_count, wb_overflow, scrub_addr
   );

   modport slave (
      input  wr_en, wr_addr, wr_code, rd_req, rd_addr, scrub_en,
      output rd_valid, rd_data, rd_err, err_count, wb_overflow, scrub_addr
   );
endinterface

// File: rtl/edc_mem_reader.sv
// Hamming(7,4) codeword store: 2-cycle corrected reads, write-back of corrected
// words through a one-entry slot, and an idle-time scrubber.
module edc_mem_reader #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   edc_mem_reader_if.slave   bus
);
   localparam int unsigned CW = 7;

   logic [CW-1:0]    mem_q [DEPTH];

   logic             s1_vld_q, s1_vld_d;
   logic             s1_ext_q, s1_ext_d;
   logic             s1_nowb_q, s1_nowb_d;
   logic [AW-1:0]    s1_addr_q, s1_addr_d;
   logic [CW-1:0]    s1_code_q;

   logic             rd_valid_q, rd_valid_d;
   logic [3:0]       rd_data_q, rd_data_d;
   logic             rd_err_q, rd_err_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             wb_overflow_q, wb_overflow_d;
   logic [AW-1:0]    scrub_addr_q, scrub_addr_d;

   logic             wb_vld_q, wb_vld_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [CW-1:0]    wb_code_q, wb_code_d;

   logic             issue_scrub_c;
   logic [AW-1:0]    s0_addr_c;
   logic [2:0]       syn_c;
   logic [CW-1:0]    fixed_c;
   logic             err_c;
   logic             wr_s1_c, wr_wb_c, wb_fire_c, wb_free_c, want_wb_c;

   // Stage 0: external reads win; the scrubber only uses idle slots with no pending write-back
   assign issue_scrub_c = !bus.rd_req && bus.scrub_en && !wb_vld_q;
   assign s0_addr_c     = bus.rd_req ? bus.rd_addr : scrub_addr_q;

   assign syn_c   = {s1_code_q[3] ^ s1_code_q[4] ^ s1_code_q[5] ^ s1_code_q[6],
                     s1_code_q[1] ^ s1_code_q[2] ^ s1_code_q[5] ^ s1_code_q[6],
                     s1_code_q[0] ^ s1_code_q[2] ^ s1_code_q[4] ^ s1_code_q[6]};
   assign fixed_c = (syn_c == 3'd0) ? s1_code_q : (s1_code_q ^ (CW'(1) << (syn_c - 3'd1)));
   assign err_c   = s1_vld_q && (syn_c != 3'd0);

   assign wr_s1_c   = bus.wr_en && (bus.wr_addr == s1_addr_q);
   assign wr_wb_c   = bus.wr_en && (bus.wr_addr == wb_addr_q);
   assign wb_fire_c = wb_vld_q && !bus.wr_en;
   assign wb_free_c = !wb_vld_q || wb_fire_c || wr_wb_c;
   assign want_wb_c = err_c && !s1_nowb_q && !wr_s1_c;

   // Single write port: external writes first, then the pending write-back
   always_ff @(posedge clk) begin
      if (bus.wr_en)     mem_q[bus.wr_addr] <= bus.wr_code;
      else if (wb_vld_q) mem_q[wb_addr_q]   <= wb_code_q;
   end

   always_comb begin
      s1_vld_d      = bus.rd_req || issue_scrub_c;
      s1_ext_d      = bus.rd_req;
      s1_addr_d     = s0_addr_c;
      s1_nowb_d     = bus.wr_en && (bus.wr_addr == s0_addr_c);
      scrub_addr_d  = scrub_addr_q;
      rd_valid_d    = s1_vld_q && s1_ext_q;
      rd_data_d     = rd_data_q;
      rd_err_d      = rd_err_q;
      err_count_d   = err_count_q;
      wb_overflow_d = wb_overflow_q;
      wb_vld_d      = wb_vld_q && !wb_fire_c && !wr_wb_c;
      wb_addr_d     = wb_addr_q;
      wb_code_d     = wb_code_q;

      if (issue_scrub_c) scrub_addr_d = scrub_addr_q + AW'(1);
      if (rd_valid_d) begin
         rd_data_d = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
         rd_err_d  = err_c;
      end
      if (err_c && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
      // A stale-marked or overwritten entry never reaches the slot
      if (want_wb_c) begin
         if (wb_free_c) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = s1_addr_q;
            wb_code_d = fixed_c;
         end else begin
            wb_overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q      <= 1'b0;
         s1_ext_q      <= 1'b0;
         s1_nowb_q     <= 1'b0;
         s1_addr_q     <= '0;
         s1_code_q     <= '0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
         rd_err_q      <= 1'b0;
         err_count_q   <= '0;
         wb_overflow_q <= 1'b0;
         scrub_addr_q  <= '0;
         wb_vld_q      <= 1'b0;
         wb_addr_q     <= '0;
         wb_code_q     <= '0;
      end else begin
         s1_vld_q      <= s1_vld_d;
         s1_ext_q      <= s1_ext_d;
         s1_nowb_q     <= s1_nowb_d;
         s1_addr_q     <= s1_addr_d;
         s1_code_q     <= mem_q[s0_addr_c];
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
         rd_err_q      <= rd_err_d;
         err_count_q   <= err_count_d;
         wb_overflow_q <= wb_overflow_d;
         scrub_addr_q  <= scrub_addr_d;
         wb_vld_q      <= wb_vld_d;
         wb_addr_q     <= wb_addr_d;
         wb_code_q     <= wb_code_d;
      end
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_err      = rd_err_q;
   assign bus.err_count   = err_count_q;
   assign bus.wb_overflow = wb_overflow_q;
   assign bus.scrub_addr  = scrub_addr_q;
endmodule
